// File: rtl/hdmi_i2c_cfg_seq_if.sv
// Request/handshake bundle between the config sequencer (master side) and the I2C byte engine (slave side).
// One write request is in flight at a time; the engine reports completion through busy/success.
interface hdmi_i2c_cfg_seq_if;
    logic       i2c_wt_req;
    logic       i2c_rd_req;
    logic [7:0] i2c_sla_addr;
    logic [7:0] i2c_sub_addr;
    logic [7:0] i2c_data_w;
    logic       i2c_busy;
    logic       i2c_success;

    modport master (
        output i2c_wt_req,
        output i2c_rd_req,
        output i2c_sla_addr,
        output i2c_sub_addr,
        output i2c_data_w,
        input  i2c_busy,
        input  i2c_success
    );

    modport slave (
        input  i2c_wt_req,
        input  i2c_rd_req,
        input  i2c_sla_addr,
        input  i2c_sub_addr,
        input  i2c_data_w,
        output i2c_busy,
        output i2c_success
    );
endinterface

// File: rtl/hdmi_i2c_cfg_seq.sv
// HDMI transmitter register-table sequencer: power wait, then one retried byte write per table entry.
// Moore outputs (no comb path from inputs); waits on i2c_busy, never issues a request while the engine is busy.
module hdmi_i2c_cfg_seq #(
    parameter logic [7:0]  SLA_ADDR     = 8'h72,
    parameter int unsigned TABLE_LEN    = 12,
    parameter logic [23:0] PWR_WAIT     = 24'd5_000_000,
    parameter logic [15:0] GAP_CYCLES   = 16'd200,
    parameter int unsigned MAX_RETRY    = 3,
    parameter logic [19:0] BUSY_TIMEOUT = 20'd100_000
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      cfg_restart_i,
    hdmi_i2c_cfg_seq_if.master        i2c,
    output logic                      cfg_busy_o,
    output logic                      cfg_done_o,
    output logic                      cfg_error_o,
    output logic [3:0]                err_index_o
);

    localparam logic [3:0]  LAST_IDX  = 4'(TABLE_LEN - 1);
    localparam logic [2:0]  RETRY_MAX = 3'(MAX_RETRY);
    localparam logic [19:0] ACPT_LAST = 20'd7;

    typedef enum logic [2:0] {
        S_PWR, S_GAP, S_REQ, S_ACPT, S_XFER, S_CHK, S_DONE, S_FAIL
    } state_t;

    state_t      state_q, state_d;
    logic [23:0] pwr_cnt_q, pwr_cnt_d;
    logic [15:0] gap_cnt_q, gap_cnt_d;
    logic [19:0] tmo_cnt_q, tmo_cnt_d;
    logic [2:0]  retry_q, retry_d;
    logic [3:0]  idx_q, idx_d;
    logic [3:0]  err_idx_q, err_idx_d;
    logic [7:0]  sub_q, sub_d;
    logic [7:0]  data_q, data_d;
    logic        ok_q, ok_d;

    logic pwr_end, gap_end, acpt_tmo, xfer_tmo, is_last, retry_left;
    logic [15:0] tbl_entry;

    function automatic logic [15:0] cfg_table(input logic [3:0] i);
        case (i)
            4'd0:    cfg_table = 16'h4110;
            4'd1:    cfg_table = 16'h9803;
            4'd2:    cfg_table = 16'h9AE0;
            4'd3:    cfg_table = 16'h9C30;
            4'd4:    cfg_table = 16'h9D61;
            4'd5:    cfg_table = 16'hA2A4;
            4'd6:    cfg_table = 16'hA3A4;
            4'd7:    cfg_table = 16'hE0D0;
            4'd8:    cfg_table = 16'hF900;
            4'd9:    cfg_table = 16'h1500;
            4'd10:   cfg_table = 16'h1630;
            4'd11:   cfg_table = 16'hAF06;
            default: cfg_table = 16'h0000;
        endcase
    endfunction

    // Gap only counts bus-idle cycles, so a retry after a busy timeout waits for the engine to let go.
    assign pwr_end    = ({1'b0, pwr_cnt_q} + 25'd1) >= {1'b0, PWR_WAIT};
    assign gap_end    = !i2c.i2c_busy && (({1'b0, gap_cnt_q} + 17'd1) >= {1'b0, GAP_CYCLES});
    assign acpt_tmo   = !i2c.i2c_busy && (tmo_cnt_q >= ACPT_LAST);
    assign xfer_tmo   = i2c.i2c_busy && (tmo_cnt_q >= BUSY_TIMEOUT);
    assign is_last    = (idx_q == LAST_IDX);
    assign retry_left = (retry_q < RETRY_MAX);
    assign tbl_entry  = cfg_table(idx_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_PWR;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_PWR:  if (pwr_end) state_d = S_GAP;
            S_GAP:  if (gap_end) state_d = S_REQ;
            S_REQ:  state_d = S_ACPT;
            S_ACPT: begin
                if (i2c.i2c_busy)  state_d = S_XFER;
                else if (acpt_tmo) state_d = S_CHK;
            end
            S_XFER: if (!i2c.i2c_busy || xfer_tmo) state_d = S_CHK;
            S_CHK: begin
                if (ok_q)            state_d = is_last ? S_DONE : S_GAP;
                else if (retry_left) state_d = S_GAP;
                else                 state_d = S_FAIL;
            end
            S_DONE, S_FAIL: if (cfg_restart_i) state_d = S_GAP;
            default: state_d = S_PWR;
        endcase
    end

    always_comb begin
        i2c.i2c_wt_req   = (state_q == S_REQ);
        i2c.i2c_rd_req   = 1'b0;
        i2c.i2c_sla_addr = SLA_ADDR;
        i2c.i2c_sub_addr = sub_q;
        i2c.i2c_data_w   = data_q;
        cfg_busy_o       = (state_q != S_DONE) && (state_q != S_FAIL);
        cfg_done_o       = (state_q == S_DONE);
        cfg_error_o      = (state_q == S_FAIL);
        err_index_o      = err_idx_q;
    end

    always_comb begin
        pwr_cnt_d = pwr_cnt_q;
        gap_cnt_d = 16'd0;
        tmo_cnt_d = 20'd0;
        retry_d   = retry_q;
        idx_d     = idx_q;
        err_idx_d = err_idx_q;
        sub_d     = sub_q;
        data_d    = data_q;
        ok_d      = ok_q;
        case (state_q)
            S_PWR: if (pwr_cnt_q != '1) pwr_cnt_d = pwr_cnt_q + 24'd1;
            S_GAP: begin
                if (!i2c.i2c_busy && gap_cnt_q != '1) gap_cnt_d = gap_cnt_q + 16'd1;
                if (gap_end) begin
                    sub_d  = tbl_entry[15:8];
                    data_d = tbl_entry[7:0];
                end
            end
            // The accepting busy cycle is the first one counted toward the transfer timeout.
            S_ACPT: begin
                ok_d = 1'b0;
                if (i2c.i2c_busy)           tmo_cnt_d = 20'd1;
                else if (tmo_cnt_q != '1)   tmo_cnt_d = tmo_cnt_q + 20'd1;
            end
            S_XFER: begin
                ok_d = !i2c.i2c_busy && i2c.i2c_success;
                if (tmo_cnt_q != '1) tmo_cnt_d = tmo_cnt_q + 20'd1;
            end
            S_CHK: begin
                if (ok_q) begin
                    retry_d = 3'd0;
                    if (!is_last) idx_d = idx_q + 4'd1;
                end else if (retry_left) begin
                    retry_d = retry_q + 3'd1;
                end else begin
                    err_idx_d = idx_q;
                end
            end
            S_DONE, S_FAIL: begin
                if (cfg_restart_i) begin
                    idx_d     = 4'd0;
                    retry_d   = 3'd0;
                    err_idx_d = 4'd0;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwr_cnt_q <= 24'd0;
            gap_cnt_q <= 16'd0;
            tmo_cnt_q <= 20'd0;
            retry_q   <= 3'd0;
            idx_q     <= 4'd0;
            err_idx_q <= 4'd0;
            sub_q     <= 8'd0;
            data_q    <= 8'd0;
            ok_q      <= 1'b0;
        end else begin
            pwr_cnt_q <= pwr_cnt_d;
            gap_cnt_q <= gap_cnt_d;
            tmo_cnt_q <= tmo_cnt_d;
            retry_q   <= retry_d;
            idx_q     <= idx_d;
            err_idx_q <= err_idx_d;
            sub_q     <= sub_d;
            data_q    <= data_d;
            ok_q      <= ok_d;
        end
    end

endmodule

// File: tb/tb_hdmi_i2c_cfg_seq.sv
// Bench for hdmi_i2c_cfg_seq: behavioural I2C engine, per-attempt outcome tables and a table-walk reference.
module tb_hdmi_i2c_cfg_seq;

    localparam int PWR = 10;
    localparam int GAP = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cfg_restart;
    logic       cfg_busy, cfg_done, cfg_error;
    logic [3:0] err_index;

    hdmi_i2c_cfg_seq_if bus();

    hdmi_i2c_cfg_seq #(
        .PWR_WAIT    (24'd10),
        .GAP_CYCLES  (16'd4),
        .BUSY_TIMEOUT(20'd100)
    ) u_dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cfg_restart_i(cfg_restart),
        .i2c          (bus),
        .cfg_busy_o   (cfg_busy),
        .cfg_done_o   (cfg_done),
        .cfg_error_o  (cfg_error),
        .err_index_o  (err_index)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [7:0] tsub [12] = '{8'h41, 8'h98, 8'h9A, 8'h9C, 8'h9D, 8'hA2, 8'hA3, 8'hE0, 8'hF9, 8'h15, 8'h16, 8'hAF};
    logic [7:0] tdat [12] = '{8'h10, 8'h03, 8'hE0, 8'h30, 8'h61, 8'hA4, 8'hA4, 8'hD0, 8'h00, 8'h00, 8'h30, 8'h06};

    int total = 0;
    int bad   = 0;

    // Engine behaviour knobs and observation state
    bit          nack_tab [12][4];
    bit          no_busy, long_first, long_done;
    int          att [12];
    logic [15:0] obs_q [$];
    logic [15:0] exp_q [$];
    bit          exp_done, exp_err;
    int          exp_idx;
    int          last_req_cyc, last_fall_cyc, first_req_cyc, rel_cyc, rs_cyc;
    logic [15:0] cur_sd;

    typedef struct {
        int nack_e;
        int nack_n;
        bit nobusy;
        int exp_n;
        bit exp_done;
        bit exp_err;
        int exp_idx;
    } vec_t;
    vec_t vecs [4];

    task automatic chk_eq(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_ge(input string nm, input int act, input int lim);
        total++;
        if (act < lim) begin
            bad++;
            $display("FAIL %s: got %0d expected >= %0d", nm, act, lim);
        end
    endtask

    task automatic chk_le(input string nm, input int act, input int lim);
        total++;
        if (act > lim) begin
            bad++;
            $display("FAIL %s: got %0d expected <= %0d", nm, act, lim);
        end
    endtask

    function automatic int find_e(input logic [7:0] s);
        for (int i = 0; i < 12; i++) if (tsub[i] == s) return i;
        return 0;
    endfunction

    // Reference: walk the table, each entry gets up to 4 attempts, first failed entry ends the run.
    function automatic void build_ref();
        bit passed;
        exp_q.delete();
        exp_done = 0; exp_err = 0; exp_idx = 0;
        for (int e = 0; e < 12; e++) begin
            passed = 0;
            for (int a = 0; a < 4 && !passed; a++) begin
                exp_q.push_back({tsub[e], tdat[e]});
                passed = !no_busy && !nack_tab[e][a] && !(long_first && e == 0 && a == 0);
            end
            if (!passed) begin
                exp_err = 1;
                exp_idx = e;
                return;
            end
        end
        exp_done = 1;
    endfunction

    // Behavioural I2C engine plus request monitor, evaluated on the falling edge.
    initial begin : engine
        int ph, w, len, e, a;
        bit outc, lng;
        ph = 0; w = 0; len = 0; outc = 0; lng = 0;
        bus.i2c_busy = 1'b0;
        bus.i2c_success = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                bus.i2c_busy = 1'b0;
                bus.i2c_success = 1'b0;
                ph = 0;
                obs_q.delete();
                for (int i = 0; i < 12; i++) att[i] = 0;
                last_req_cyc = -1000;
                last_fall_cyc = -1000;
            end else begin
                if (cfg_restart) begin
                    obs_q.delete();
                    for (int i = 0; i < 12; i++) att[i] = 0;
                end
                if (bus.i2c_wt_req) begin
                    chk_eq("req_while_busy", int'(bus.i2c_busy), 0);
                    chk_ge("req_spacing", cyc - last_req_cyc, GAP + 2);
                    chk_ge("req_after_fall", cyc - last_fall_cyc, GAP);
                    if (obs_q.size() == 0) first_req_cyc = cyc;
                    last_req_cyc = cyc;
                    cur_sd = {bus.i2c_sub_addr, bus.i2c_data_w};
                    obs_q.push_back(cur_sd);
                end
                case (ph)
                    0: if (bus.i2c_wt_req && !no_busy) begin
                        e = find_e(bus.i2c_sub_addr);
                        a = (att[e] > 3) ? 3 : att[e];
                        outc = !nack_tab[e][a];
                        att[e]++;
                        lng = long_first && !long_done;
                        if (lng) long_done = 1;
                        w = 1 + $urandom_range(0, 2);
                        ph = 1;
                    end
                    1: begin
                        w--;
                        if (w == 0) begin
                            bus.i2c_busy = 1'b1;
                            len = lng ? 200 : $urandom_range(1, 6);
                            ph = 2;
                        end
                    end
                    default: begin
                        len--;
                        if (len == 0) begin
                            bus.i2c_busy = 1'b0;
                            bus.i2c_success = outc;
                            last_fall_cyc = cyc;
                            chk_eq("data_stable", int'({bus.i2c_sub_addr, bus.i2c_data_w}), int'(cur_sd));
                            ph = 0;
                        end
                    end
                endcase
            end
        end
    end

    task automatic chk_reset_vals(input string tag);
        chk_eq({tag, "_wt_req"}, int'(bus.i2c_wt_req), 0);
        chk_eq({tag, "_rd_req"}, int'(bus.i2c_rd_req), 0);
        chk_eq({tag, "_sla"},    int'(bus.i2c_sla_addr), 'h72);
        chk_eq({tag, "_sub"},    int'(bus.i2c_sub_addr), 0);
        chk_eq({tag, "_data"},   int'(bus.i2c_data_w), 0);
        chk_eq({tag, "_busy"},   int'(cfg_busy), 1);
        chk_eq({tag, "_done"},   int'(cfg_done), 0);
        chk_eq({tag, "_error"},  int'(cfg_error), 0);
        chk_eq({tag, "_errix"},  int'(err_index), 0);
    endtask

    task automatic do_reset();
        @(posedge clk); #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        rel_cyc = cyc;
    endtask

    task automatic pulse_restart();
        @(posedge clk); #1 cfg_restart = 1'b1;
        rs_cyc = cyc;
        @(posedge clk); #1 cfg_restart = 1'b0;
    endtask

    task automatic wait_end(input string tag);
        int n;
        n = 0;
        while (!(cfg_done || cfg_error) && n < 4000) begin
            @(negedge clk);
            n++;
        end
        chk_eq({tag, "_finished"}, int'(cfg_done || cfg_error), 1);
        repeat (30) @(negedge clk);
    endtask

    task automatic cmp_ref(input string tag);
        chk_eq({tag, "_npulses"}, obs_q.size(), exp_q.size());
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++)
            chk_eq({tag, "_pulse"}, int'(obs_q[i]), int'(exp_q[i]));
        chk_eq({tag, "_done"},  int'(cfg_done), int'(exp_done));
        chk_eq({tag, "_error"}, int'(cfg_error), int'(exp_err));
        if (exp_err) chk_eq({tag, "_errix"}, int'(err_index), exp_idx);
        chk_eq({tag, "_cfgbusy"}, int'(cfg_busy), 0);
    endtask

    task automatic clear_tab();
        for (int e = 0; e < 12; e++)
            for (int a = 0; a < 4; a++) nack_tab[e][a] = 0;
    endtask

    initial begin : main
        int n;
        rst_n = 1'b0;
        cfg_restart = 1'b0;
        no_busy = 0; long_first = 0; long_done = 0;
        clear_tab();
        vecs[0] = '{nack_e: -1, nack_n: 0, nobusy: 0, exp_n: 12, exp_done: 1, exp_err: 0, exp_idx: 0};
        vecs[1] = '{nack_e:  3, nack_n: 2, nobusy: 0, exp_n: 14, exp_done: 1, exp_err: 0, exp_idx: 0};
        vecs[2] = '{nack_e: -1, nack_n: 0, nobusy: 1, exp_n:  4, exp_done: 0, exp_err: 1, exp_idx: 0};
        vecs[3] = '{nack_e:  5, nack_n: 4, nobusy: 0, exp_n:  9, exp_done: 0, exp_err: 1, exp_idx: 5};

        #12;
        chk_reset_vals("reset");

        for (int r = 0; r < 4; r++) begin
            clear_tab();
            for (int a = 0; a < vecs[r].nack_n; a++) nack_tab[vecs[r].nack_e][a] = 1;
            no_busy = vecs[r].nobusy;
            build_ref();
            do_reset();
            wait_end("vec");
            chk_eq("vec_npulses", obs_q.size(), vecs[r].exp_n);
            chk_eq("vec_done",    int'(cfg_done), int'(vecs[r].exp_done));
            chk_eq("vec_error",   int'(cfg_error), int'(vecs[r].exp_err));
            chk_eq("vec_errix",   int'(err_index), vecs[r].exp_idx);
            cmp_ref("vec");
        end

        // Restart out of FAIL clears error state and reruns without a power wait
        clear_tab();
        build_ref();
        pulse_restart();
        chk_eq("rs_fail_busy",  int'(cfg_busy), 1);
        chk_eq("rs_fail_error", int'(cfg_error), 0);
        chk_eq("rs_fail_errix", int'(err_index), 0);
        wait_end("rs_fail");
        cmp_ref("rs_fail");

        // Randomized outcome tables
        for (int it = 0; it < 5; it++) begin
            for (int e = 0; e < 12; e++)
                for (int a = 0; a < 4; a++) nack_tab[e][a] = ($urandom_range(0, 3) == 0);
            if (it % 2 == 1) begin
                n = $urandom_range(0, 11);
                for (int a = 0; a < 4; a++) nack_tab[n][a] = 1;
            end
            build_ref();
            do_reset();
            wait_end("rand");
            cmp_ref("rand");
        end

        // Busy held past the transfer timeout on the very first attempt
        clear_tab();
        long_first = 1; long_done = 0;
        build_ref();
        do_reset();
        wait_end("long");
        cmp_ref("long");
        long_first = 0;

        // Async reset in the middle of entry 7's transfer
        build_ref();
        do_reset();
        n = 0;
        while (!(obs_q.size() >= 8 && bus.i2c_busy) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk_eq("mid_reached", int'(obs_q.size() >= 8 && bus.i2c_busy), 1);
        if (obs_q.size() >= 8) chk_eq("mid_entry7", int'(obs_q[7]), 'hE0D0);
        #2 rst_n = 1'b0;
        #1 chk_reset_vals("midrst");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        rel_cyc = cyc;
        wait_end("after_rst");
        cmp_ref("after_rst");
        chk_ge("pwr_wait", first_req_cyc - rel_cyc, PWR);

        // Restart from DONE: rerun without the power wait
        pulse_restart();
        chk_eq("rs_done_busy", int'(cfg_busy), 1);
        chk_eq("rs_done_done", int'(cfg_done), 0);
        wait_end("rs_done");
        cmp_ref("rs_done");
        chk_le("rs_no_pwr", first_req_cyc - rs_cyc, GAP + 3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule
